// File: rtl/ask4_symbol_gen.sv
// ask4_symbol_gen
// Pseudo-random 4-ASK symbol source feeding the TX pulse-shaping filter.
// A 15-bit PRBS (x^15+x^14+1) supplies two bits per symbol. The bits are
// Gray-mapped to 1s17 amplitude levels and zero-stuffed to OSR samples
// per symbol. A symbol strobe, the bit pair and a symbol counter are
// provided for downstream BER checking.
// Optional feature: define ASK4_TEST_PATTERN_EN to add the tp_mode input,
// which replaces the PRBS with the fixed bit cycle 00,01,11,10.

module ask4_symbol_gen #(
   parameter int unsigned OSR       = 4,
   parameter logic [14:0] LFSR_SEED = 15'h4000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
`ifdef ASK4_TEST_PATTERN_EN
   input  logic               tp_mode,
`endif
   output logic signed [17:0] x_out,
   output logic               sym_strobe,
   output logic [1:0]         sym_bits,
   output logic [15:0]        sym_count,
   output logic               active
);

   localparam int unsigned    PW         = (OSR > 2) ? $clog2(OSR) : 1;
   localparam logic [PW-1:0]  LAST_PHASE = PW'(OSR - 1);
   localparam logic [14:0]    SEED       = (LFSR_SEED == 15'd0) ? 15'h0001 : LFSR_SEED;

   localparam logic signed [17:0] LEVEL_M3 = -18'sd98304;
   localparam logic signed [17:0] LEVEL_M1 = -18'sd32768;
   localparam logic signed [17:0] LEVEL_P1 =  18'sd32768;
   localparam logic signed [17:0] LEVEL_P3 =  18'sd98304;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [PW-1:0]      phase;
   logic [PW-1:0]      phase_nxt;
   logic [14:0]        lfsr;
   logic [14:0]        lfsr_nxt;
   logic [14:0]        lfsr_adv;
   logic [1:0]         emit_bits;
   logic signed [17:0] level;
   logic signed [17:0] x_nxt;
   logic               strobe_nxt;
   logic [1:0]         bits_nxt;
   logic [15:0]        count_nxt;
   logic               emit;
`ifdef ASK4_TEST_PATTERN_EN
   logic [1:0]         tp_idx;
   logic [1:0]         tp_idx_adv;
   logic [1:0]         tp_idx_nxt;
`endif

   // One Fibonacci step: feedback from the two oldest bits enters at bit 0.
   function automatic logic [14:0] lfsr_step(input logic [14:0] s);
      return {s[13:0], s[14] ^ s[13]};
   endfunction

   // Pick the bit pair for the next symbol and where the sequence source moves to.
   always_comb begin
      emit_bits = lfsr[14:13];
      lfsr_adv  = lfsr_step(lfsr_step(lfsr));
`ifdef ASK4_TEST_PATTERN_EN
      tp_idx_adv = tp_idx;
      if (tp_mode) begin
         emit_bits  = {tp_idx[1], tp_idx[1] ^ tp_idx[0]};
         lfsr_adv   = lfsr;
         tp_idx_adv = tp_idx + 2'd1;
      end
`endif
   end

   // Gray map: adjacent levels differ in one bit, outer levels kept at 0.75.
   always_comb begin
      level = LEVEL_M3;
      case (emit_bits)
         2'b00:   level = LEVEL_M3;
         2'b01:   level = LEVEL_M1;
         2'b11:   level = LEVEL_P1;
         2'b10:   level = LEVEL_P3;
         default: level = LEVEL_M3;
      endcase
   end

   // Next-state logic: run is only looked at on the last sample of a symbol or in IDLE.
   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase;
      lfsr_nxt   = lfsr;
      x_nxt      = '0;
      strobe_nxt = 1'b0;
      bits_nxt   = sym_bits;
      count_nxt  = sym_count;
      emit       = 1'b0;
`ifdef ASK4_TEST_PATTERN_EN
      tp_idx_nxt = tp_idx;
`endif
      case (state)
         IDLE: begin
            if (run) begin
               emit      = 1'b1;
               state_nxt = RUN;
               phase_nxt = '0;
            end
         end
         RUN: begin
            if (phase == LAST_PHASE) begin
               phase_nxt = '0;
               if (run) begin
                  emit = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               phase_nxt = phase + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            phase_nxt = '0;
         end
      endcase
      if (emit) begin
         x_nxt      = level;
         strobe_nxt = 1'b1;
         bits_nxt   = emit_bits;
         count_nxt  = sym_count + 16'd1;
         lfsr_nxt   = lfsr_adv;
`ifdef ASK4_TEST_PATTERN_EN
         tp_idx_nxt = tp_idx_adv;
`endif
      end
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         phase      <= '0;
         lfsr       <= SEED;
         x_out      <= '0;
         sym_strobe <= 1'b0;
         sym_bits   <= 2'b00;
         sym_count  <= 16'd0;
`ifdef ASK4_TEST_PATTERN_EN
         tp_idx     <= 2'd0;
`endif
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         lfsr       <= lfsr_nxt;
         x_out      <= x_nxt;
         sym_strobe <= strobe_nxt;
         sym_bits   <= bits_nxt;
         sym_count  <= count_nxt;
`ifdef ASK4_TEST_PATTERN_EN
         tp_idx     <= tp_idx_nxt;
`endif
      end
   end

   assign active = (state == RUN);

endmodule
